// File: rtl/ac_table_loader_if.sv
// Record-stream, RAM-write and status bundle between a host and ac_table_loader.
// The host drives START and the IN_* record fields; the loader drives everything else.
interface ac_table_loader_if;
    logic        START;
    logic        IN_VALID;
    logic        IN_READY;
    logic        IN_KIND;
    logic [7:0]  IN_STATE;
    logic [3:0]  IN_CHARA;
    logic [7:0]  IN_NEXT;
    logic        IN_LAST;
    logic        GOTO_WE;
    logic [11:0] GOTO_WADDR;
    logic [7:0]  GOTO_WDATA;
    logic        FAIL_WE;
    logic [11:0] FAIL_WADDR;
    logic [7:0]  FAIL_WDATA;
    logic        BUSY;
    logic        DONE;
    logic        ERR;
    logic [12:0] GOTO_CNT;
    logic [8:0]  FAIL_CNT;

    modport master (
        output START, IN_VALID, IN_KIND, IN_STATE, IN_CHARA, IN_NEXT, IN_LAST,
        input  IN_READY, GOTO_WE, GOTO_WADDR, GOTO_WDATA, FAIL_WE, FAIL_WADDR,
               FAIL_WDATA, BUSY, DONE, ERR, GOTO_CNT, FAIL_CNT
    );

    modport slave (
        input  START, IN_VALID, IN_KIND, IN_STATE, IN_CHARA, IN_NEXT, IN_LAST,
        output IN_READY, GOTO_WE, GOTO_WADDR, GOTO_WDATA, FAIL_WE, FAIL_WADDR,
               FAIL_WDATA, BUSY, DONE, ERR, GOTO_CNT, FAIL_CNT
    );
endinterface

// File: rtl/ac_table_loader.sv
// Writes Aho-Corasick goto/failure tables from a record stream, all outputs registered.
// Define AC_LOADER_CLEAR_EN to add the default-fill sweep (CLEAR state) before each load.
module ac_table_loader #(
    parameter logic [7:0] MAX_STATE = 8'd255,
    parameter logic [7:0] NO_TRANS  = 8'hFF
) (
    input logic          CLK,
    input logic          RST,
    ac_table_loader_if.slave bus
);
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_LOAD  = 2'd2,
        S_DONE  = 2'd3
`ifdef AC_LOADER_CLEAR_EN
        , S_CLEAR = 2'd1
`endif
    } state_t;

    state_t      state_q, state_d;
    logic        in_ready_q, in_ready_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        err_q, err_d;
    logic        goto_we_q, goto_we_d;
    logic [11:0] goto_waddr_q, goto_waddr_d;
    logic [7:0]  goto_wdata_q, goto_wdata_d;
    logic        fail_we_q, fail_we_d;
    logic [11:0] fail_waddr_q, fail_waddr_d;
    logic [7:0]  fail_wdata_q, fail_wdata_d;
    logic [12:0] goto_cnt_q, goto_cnt_d;
    logic [8:0]  fail_cnt_q, fail_cnt_d;
`ifdef AC_LOADER_CLEAR_EN
    // Bit 12 marks "address 4095 already issued" so the exit cycle comes after the last write.
    logic [12:0] sweep_q, sweep_d;
`else
    logic [7:0]  unused_no_trans;
    assign unused_no_trans = NO_TRANS;
`endif

    // A negative margin (borrow out) means the field exceeds MAX_STATE.
    logic [8:0] st_margin, nx_margin;
    logic       rec_bad;
    assign st_margin = {1'b0, MAX_STATE} - {1'b0, bus.IN_STATE};
    assign nx_margin = {1'b0, MAX_STATE} - {1'b0, bus.IN_NEXT};
    assign rec_bad   = st_margin[8] | nx_margin[8];

    always_comb begin
        state_d      = state_q;
        err_d        = err_q;
        goto_we_d    = 1'b0;
        goto_waddr_d = goto_waddr_q;
        goto_wdata_d = goto_wdata_q;
        fail_we_d    = 1'b0;
        fail_waddr_d = fail_waddr_q;
        fail_wdata_d = fail_wdata_q;
        goto_cnt_d   = goto_cnt_q;
        fail_cnt_d   = fail_cnt_q;
`ifdef AC_LOADER_CLEAR_EN
        sweep_d      = sweep_q;
`endif
        case (state_q)
            S_IDLE, S_DONE: begin
                if (bus.START) begin
                    err_d      = 1'b0;
                    goto_cnt_d = 13'd0;
                    fail_cnt_d = 9'd0;
`ifdef AC_LOADER_CLEAR_EN
                    // Address 0 is issued straight from the START cycle.
                    state_d      = S_CLEAR;
                    goto_we_d    = 1'b1;
                    goto_waddr_d = 12'd0;
                    goto_wdata_d = NO_TRANS;
                    fail_we_d    = 1'b1;
                    fail_waddr_d = 12'd0;
                    fail_wdata_d = 8'h00;
                    sweep_d      = 13'd1;
`else
                    state_d      = S_LOAD;
`endif
                end
            end
`ifdef AC_LOADER_CLEAR_EN
            S_CLEAR: begin
                if (sweep_q[12]) begin
                    state_d = S_LOAD;
                end else begin
                    goto_we_d    = 1'b1;
                    goto_waddr_d = sweep_q[11:0];
                    goto_wdata_d = NO_TRANS;
                    if (sweep_q[11:8] == 4'd0) begin
                        fail_we_d    = 1'b1;
                        fail_waddr_d = {4'b0, sweep_q[7:0]};
                        fail_wdata_d = 8'h00;
                    end
                    sweep_d = sweep_q + 13'd1;
                end
            end
`endif
            S_LOAD: begin
                if (bus.IN_VALID && in_ready_q) begin
                    if (rec_bad) begin
                        err_d = 1'b1;
                    end else if (!bus.IN_KIND) begin
                        goto_we_d    = 1'b1;
                        goto_waddr_d = {bus.IN_STATE, bus.IN_CHARA};
                        goto_wdata_d = bus.IN_NEXT;
                        if (goto_cnt_q != 13'd4096) goto_cnt_d = goto_cnt_q + 13'd1;
                    end else begin
                        fail_we_d    = 1'b1;
                        fail_waddr_d = {4'b0, bus.IN_STATE};
                        fail_wdata_d = bus.IN_NEXT;
                        if (fail_cnt_q != 9'd256) fail_cnt_d = fail_cnt_q + 9'd1;
                    end
                    if (bus.IN_LAST) state_d = S_DONE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Status flags follow the next state so they line up with the state register.
        in_ready_d = (state_d == S_LOAD);
        done_d     = (state_d == S_DONE);
        busy_d     = (state_d == S_LOAD);
`ifdef AC_LOADER_CLEAR_EN
        if (state_d == S_CLEAR) busy_d = 1'b1;
`endif
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q      <= S_IDLE;
            in_ready_q   <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
            goto_we_q    <= 1'b0;
            goto_waddr_q <= 12'd0;
            goto_wdata_q <= 8'd0;
            fail_we_q    <= 1'b0;
            fail_waddr_q <= 12'd0;
            fail_wdata_q <= 8'd0;
            goto_cnt_q   <= 13'd0;
            fail_cnt_q   <= 9'd0;
`ifdef AC_LOADER_CLEAR_EN
            sweep_q      <= 13'd0;
`endif
        end else begin
            state_q      <= state_d;
            in_ready_q   <= in_ready_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            err_q        <= err_d;
            goto_we_q    <= goto_we_d;
            goto_waddr_q <= goto_waddr_d;
            goto_wdata_q <= goto_wdata_d;
            fail_we_q    <= fail_we_d;
            fail_waddr_q <= fail_waddr_d;
            fail_wdata_q <= fail_wdata_d;
            goto_cnt_q   <= goto_cnt_d;
            fail_cnt_q   <= fail_cnt_d;
`ifdef AC_LOADER_CLEAR_EN
            sweep_q      <= sweep_d;
`endif
        end
    end

    assign bus.IN_READY   = in_ready_q;
    assign bus.BUSY       = busy_q;
    assign bus.DONE       = done_q;
    assign bus.ERR        = err_q;
    assign bus.GOTO_WE    = goto_we_q;
    assign bus.GOTO_WADDR = goto_waddr_q;
    assign bus.GOTO_WDATA = goto_wdata_q;
    assign bus.FAIL_WE    = fail_we_q;
    assign bus.FAIL_WADDR = fail_waddr_q;
    assign bus.FAIL_WDATA = fail_wdata_q;
    assign bus.GOTO_CNT   = goto_cnt_q;
    assign bus.FAIL_CNT   = fail_cnt_q;
endmodule
